// File: rtl/pwm_deadband_if.sv
// Control and gate-drive bundle for pwm_deadband.
// master drives count/duty/enable, slave returns gate outputs.
interface pwm_deadband_if #(
    parameter int CW = 4,
    parameter int DW = 5
);
    logic          i_en;
    logic [CW-1:0] i_cnt;
    logic          i_duty_wr;
    logic [DW-1:0] i_duty;
    logic          o_pwm_h;
    logic          o_pwm_l;
    logic          o_upd;

    modport master (
        output i_en, i_cnt, i_duty_wr, i_duty,
        input  o_pwm_h, o_pwm_l, o_upd
    );

    modport slave (
        input  i_en, i_cnt, i_duty_wr, i_duty,
        output o_pwm_h, o_pwm_l, o_upd
    );
endinterface

// File: rtl/pwm_deadband.sv
// Complementary PWM with double-buffered duty and dead-time insertion.
// Gate outputs are Moore decodes of the state register.
module pwm_deadband #(
    parameter int PERIOD = 15,
    parameter int CW     = $clog2(PERIOD + 1),
    parameter int DW     = CW + 1,
    parameter int DEAD   = 2
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    pwm_deadband_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        DT_H,
        HIGH,
        DT_L,
        LOW
    } state_t;

    localparam logic [3:0]    DLOAD = 4'(DEAD - 1);
    localparam logic [CW-1:0] CTOP  = CW'(PERIOD);
    localparam logic [DW-1:0] DFULL = DW'(PERIOD + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_dcnt;
    logic [3:0]    w_dcnt_nxt;
    logic [DW-1:0] r_duty_act;
    logic [DW-1:0] r_duty_shd;
    logic [DW-1:0] w_duty_sat;
    logic          r_pend;
    logic          r_upd;
    logic          w_xfer;
    logic          w_raw;

    // Transfer samples the shadow before any same-cycle write lands.
    assign w_xfer     = r_pend && (bus.i_cnt == CTOP);
    assign w_raw      = DW'(bus.i_cnt) < r_duty_act;
    assign w_duty_sat = (bus.i_duty > DFULL) ? DFULL : bus.i_duty;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_duty_act <= '0;
            r_duty_shd <= '0;
            r_pend     <= 1'b0;
            r_upd      <= 1'b0;
        end else begin
            r_upd <= w_xfer;
            if (w_xfer) begin
                r_duty_act <= r_duty_shd;
            end
            if (bus.i_duty_wr) begin
                r_duty_shd <= w_duty_sat;
                r_pend     <= 1'b1;
            end else if (w_xfer) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // A raw flip inside a dead window restarts the opposite window.
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        if (!bus.i_en) begin
            w_state_nxt = IDLE;
            w_dcnt_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = DT_L;
                    w_dcnt_nxt  = DLOAD;
                end
                LOW: begin
                    if (w_raw) begin
                        w_state_nxt = DT_H;
                        w_dcnt_nxt  = DLOAD;
                    end
                end
                HIGH: begin
                    if (!w_raw) begin
                        w_state_nxt = DT_L;
                        w_dcnt_nxt  = DLOAD;
                    end
                end
                DT_H: begin
                    if (!w_raw) begin
                        w_state_nxt = DT_L;
                        w_dcnt_nxt  = DLOAD;
                    end else if (r_dcnt == '0) begin
                        w_state_nxt = HIGH;
                    end else begin
                        w_dcnt_nxt = r_dcnt - 4'd1;
                    end
                end
                DT_L: begin
                    if (w_raw) begin
                        w_state_nxt = DT_H;
                        w_dcnt_nxt  = DLOAD;
                    end else if (r_dcnt == '0) begin
                        w_state_nxt = LOW;
                    end else begin
                        w_dcnt_nxt = r_dcnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_dcnt_nxt  = '0;
                end
            endcase
        end
    end

    assign bus.o_pwm_h = (r_state == HIGH);
    assign bus.o_pwm_l = (r_state == LOW);
    assign bus.o_upd   = r_upd;
endmodule

// File: tb/tb_pwm_deadband.sv
// Bench for pwm_deadband: duty table, shadowing, enable and reset cases.
// Expected gate levels come from the closed-form per-period waveform.
`timescale 1ns/1ps
module tb_pwm_deadband;
    localparam int PERIOD = 15;
    localparam int DEAD   = 2;
    localparam int CW     = $clog2(PERIOD + 1);
    localparam int DW     = CW + 1;

    typedef struct {
        int duty;
        int h_on;
        int l_on;
    } vec_t;

    typedef struct {
        logic h;
        logic l;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    pwm_deadband_if #(.CW(CW), .DW(DW)) bus ();

    pwm_deadband #(
        .PERIOD(PERIOD),
        .CW    (CW),
        .DW    (DW),
        .DEAD  (DEAD)
    ) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus)
    );

    exp_t sb[$];
    vec_t vecs[10];
    int   total = 0;
    int   bad   = 0;
    int   cnt;
    int   md_v;
    bit   en_v;
    bit   push_v;
    int   gap_h, gap_l;
    logic prev_h, prev_l;
    logic s_h, s_l, s_upd;
    int   h_cnt, l_cnt, upd_cnt, upd_c;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Steady-state gate levels for a given active duty and count.
    function automatic exp_t model(input int d, input int c);
        exp_t e;
        if (d == 0) begin
            e.h = 1'b0;
            e.l = 1'b1;
        end else if (d > PERIOD) begin
            e.h = 1'b1;
            e.l = 1'b0;
        end else begin
            e.h = (c >= DEAD + 1) && (c <= d);
            e.l = (c >= d + DEAD + 1) || (c == 0 && d + DEAD <= PERIOD);
        end
        return e;
    endfunction

    task automatic step(input bit wr, input int d);
        exp_t e;
        @(posedge clk);
        #1;
        cnt = (cnt == PERIOD) ? 0 : cnt + 1;
        bus.i_cnt     = cnt[CW-1:0];
        bus.i_en      = en_v;
        bus.i_duty_wr = wr;
        bus.i_duty    = d[DW-1:0];
        if (push_v) sb.push_back(model(md_v, cnt));
        @(negedge clk);
        s_h   = bus.o_pwm_h;
        s_l   = bus.o_pwm_l;
        s_upd = bus.o_upd;
        check("overlap", int'(s_h & s_l), 0);
        if (s_l && !prev_l) check("dead_h_to_l", int'(gap_h >= DEAD), 1);
        if (s_h && !prev_h) check("dead_l_to_h", int'(gap_l >= DEAD), 1);
        gap_h  = s_h ? 0 : gap_h + 1;
        gap_l  = s_l ? 0 : gap_l + 1;
        prev_h = s_h;
        prev_l = s_l;
        h_cnt += int'(s_h);
        l_cnt += int'(s_l);
        if (s_upd) begin
            upd_cnt++;
            upd_c = cnt;
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("pwm_h@cnt%0d", cnt), int'(s_h), int'(e.h));
            check($sformatf("pwm_l@cnt%0d", cnt), int'(s_l), int'(e.l));
        end
    endtask

    task automatic advance_to(input int c);
        while (cnt != c) step(1'b0, 0);
    endtask

    task automatic write_at(input int c, input int d);
        advance_to((c == 0) ? PERIOD : c - 1);
        step(1'b1, d);
    endtask

    task automatic zero_counts();
        h_cnt   = 0;
        l_cnt   = 0;
        upd_cnt = 0;
        upd_c   = -1;
    endtask

    task automatic push_exp(input logic h, input logic l);
        exp_t e;
        e.h = h;
        e.l = l;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{4, 2, 10};
        vecs[1] = '{0, 0, 16};
        vecs[2] = '{16, 16, 0};
        vecs[3] = '{31, 16, 0};
        vecs[4] = '{2, 0, 12};
        vecs[5] = '{1, 0, 13};
        vecs[6] = '{13, 11, 1};
        vecs[7] = '{15, 13, 0};
        vecs[8] = '{14, 12, 0};
        vecs[9] = '{8, 6, 6};

        rstn          = 1'b1;
        bus.i_en      = 1'b0;
        bus.i_cnt     = '0;
        bus.i_duty_wr = 1'b0;
        bus.i_duty    = '0;
        cnt    = 0;
        en_v   = 1'b0;
        push_v = 1'b0;
        md_v   = 0;
        gap_h  = 100;
        gap_l  = 100;
        prev_h = 1'b0;
        prev_l = 1'b0;
        zero_counts();

        #2 rstn = 1'b0;
        #1;
        check("rst_pwm_h", int'(bus.o_pwm_h), 0);
        check("rst_pwm_l", int'(bus.o_pwm_l), 0);
        check("rst_upd", int'(bus.o_upd), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold_h", int'(bus.o_pwm_h), 0);
        check("rst_hold_l", int'(bus.o_pwm_l), 0);
        rstn = 1'b1;
        en_v = 1'b1;

        for (int i = 0; i < 10; i++) begin
            bit found;
            zero_counts();
            write_at(5, vecs[i].duty);
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                step(1'b0, 0);
                if (s_upd) found = 1'b1;
            end
            check($sformatf("upd_seen_d%0d", vecs[i].duty), int'(found), 1);
            check($sformatf("upd_at_cnt0_d%0d", vecs[i].duty), upd_c, 0);
            advance_to(PERIOD);
            h_cnt  = 0;
            l_cnt  = 0;
            md_v   = vecs[i].duty;
            push_v = 1'b1;
            repeat (PERIOD + 1) step(1'b0, 0);
            push_v = 1'b0;
            check($sformatf("h_on_d%0d", vecs[i].duty), h_cnt, vecs[i].h_on);
            check($sformatf("l_on_d%0d", vecs[i].duty), l_cnt, vecs[i].l_on);
            check($sformatf("upd_once_d%0d", vecs[i].duty), upd_cnt, 1);
        end

        // Two writes in one period: only the later one is applied.
        zero_counts();
        write_at(5, 8);
        write_at(9, 10);
        advance_to(PERIOD);
        h_cnt = 0;
        repeat (PERIOD + 1) step(1'b0, 0);
        check("multi_wr_upd_count", upd_cnt, 1);
        check("multi_wr_upd_cnt0", upd_c, 0);
        check("multi_wr_h_on", h_cnt, 8);

        // Write coinciding with the transfer stays pending for one more period.
        zero_counts();
        write_at(5, 6);
        write_at(PERIOD, 12);
        h_cnt   = 0;
        upd_cnt = 0;
        repeat (PERIOD + 1) step(1'b0, 0);
        check("coinc_first_upd", upd_cnt, 1);
        check("coinc_first_h_on", h_cnt, 4);
        h_cnt   = 0;
        upd_cnt = 0;
        repeat (PERIOD + 1) step(1'b0, 0);
        check("coinc_second_upd", upd_cnt, 1);
        check("coinc_second_h_on", h_cnt, 10);

        // Enable drop while HIGH, then re-enable through DT_L.
        advance_to(6);
        check("dis_pre_h", int'(s_h), 1);
        en_v = 1'b0;
        step(1'b0, 0);
        step(1'b0, 0);
        check("dis_h_off", int'(s_h), 0);
        check("dis_l_off", int'(s_l), 0);
        advance_to(12);
        en_v = 1'b1;
        push_exp(1'b0, 1'b0);
        step(1'b0, 0);
        push_exp(1'b0, 1'b0);
        step(1'b0, 0);
        push_exp(1'b0, 1'b0);
        step(1'b0, 0);
        push_exp(1'b0, 1'b1);
        step(1'b0, 0);
        push_exp(1'b0, 1'b0);
        step(1'b0, 0);
        push_exp(1'b0, 1'b0);
        step(1'b0, 0);
        push_exp(1'b1, 1'b0);
        step(1'b0, 0);

        // Asynchronous reset in the middle of HIGH.
        advance_to(5);
        check("arst_pre_h", int'(s_h), 1);
        #2 rstn = 1'b0;
        #1;
        check("arst_h_now", int'(bus.o_pwm_h), 0);
        check("arst_l_now", int'(bus.o_pwm_l), 0);
        check("arst_upd_now", int'(bus.o_upd), 0);
        cnt       = 0;
        bus.i_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        prev_h = 1'b0;
        prev_l = 1'b0;
        gap_h  = 100;
        gap_l  = 100;
        zero_counts();
        repeat (2 * (PERIOD + 1)) step(1'b0, 0);
        check("post_rst_h_on", h_cnt, 0);
        check("post_rst_l_on", l_cnt, 2 * (PERIOD + 1) - DEAD);
        check("post_rst_upd", upd_cnt, 0);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
